fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction prefetch queue that sits directly upstream of the fetch stage, between instruction memory and the IF/ID boundary. It issues sequential word-addressed fetch requests to instruction memory over a request/response handshake and buffers returned instructions with their PCs. It hands them to the fetch stage one per cycle under a ready/valid handshake. On a control-flow redirect (kill/taken branch/jump/for), it flushes buffered and in-flight instructions and restarts at the target.

## Interface
- DEPTH, 4: queue entries; also the cap on buffered plus outstanding requests (power of two, ≥2).
- RESET_PC, 16'h0000: first fetch address after reset.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- redirect  in  1  flush and restart fetch at redirect_pc; has priority over all other events.
- redirect_pc  in  16  restart address.
- imem_req  out  1  fetch request valid.
- imem_addr  out  16  word address of request (= fetch_pc).
- imem_ready  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  response valid; responses return in request order, ≥1 cycle after acceptance.
- imem_rdata  in  16  returned instruction.
- deq_valid  out  1  head entry valid.
- deq_instr  out  16  head instruction.
- deq_pc  out  16  head PC.
- deq_ready  in  1  fetch stage consumes head (driven as !stall).
- count  out  $clog2(DEPTH+1)  entries currently buffered.
- err  out  1  sticky: response received with no outstanding request.

## Operation
- State: fetch_pc, resp_pc (PC of next kept response), FIFO of {instr, pc}, count, outstanding, drop_cnt, err.
- Request: imem_req = !redirect && (count + outstanding < DEPTH). Accept = imem_req && imem_ready. Accept: fetch_pc += 1 (mod 2^16), outstanding += 1.
- Response: on imem_rvalid with outstanding > 0: outstanding -= 1. If drop_cnt > 0, discard and drop_cnt -= 1. Otherwise write {imem_rdata, resp_pc} at tail, resp_pc += 1 (mod 2^16).
- Dequeue: deq_valid = (count > 0) && !redirect. Pop = deq_valid && deq_ready. Simultaneous push and pop leave count unchanged. The credit rule guarantees a push never finds the FIFO full.
- Redirect cycle:
  - Clear FIFO (count ← 0). No pop occurs.
  - fetch_pc ← redirect_pc, resp_pc ← redirect_pc.
  - drop_cnt ← outstanding − (imem_rvalid ? 1 : 0). outstanding ← the same value.
  - A response arriving in the redirect cycle is discarded.
  - No request is issued.
- Back-to-back redirects: the last one wins; drop accounting carries over.
- Outstanding includes to-be-dropped responses for credit purposes (conservative).
- err: imem_rvalid while outstanding == 0 sets err. The response is ignored. Cleared only by reset.

## Timing
- Reset values:
  - deq_valid 0, count 0, err 0, imem_req 0 while rst_n low.
  - fetch_pc = resp_pc = imem_addr = RESET_PC.
  - outstanding 0, drop_cnt 0.
  - FIFO contents don't-care.
- Assertion of rst_n low takes effect immediately (async). Deassertion is synchronous to clk by the system. Reset mid-operation abandons all in-flight responses. Those responses then set err if they arrive.
- imem_req, imem_addr, deq_* are combinational from registered state and redirect only; there is no combinational path from imem_rvalid to any output.
- No bypass: a response written at edge N is visible on deq_* after edge N.
- Minimum redirect-to-deq_valid latency:
  - redirect at cycle N.
  - Request at N+1.
  - 1-cycle memory response at N+2.
  - deq_valid at N+3.
- Steady state with 1-cycle memory and deq_ready=1: one instruction per cycle.

## Test plan
- Reset, 1-cycle memory returning mem[a]=a^16'hA5A5, deq_ready=1 → deq_pc 0,1,2,3… with deq_instr A5A5,A5A4,A5A7…, one per cycle after fill; err=0.
- deq_ready=0, DEPTH=4 → count reaches 4, imem_req stays 0 with outstanding 0. deq_ready=1 → pops resume in PC order with no loss or duplication.
- 3-cycle memory latency, 2 requests outstanding, redirect to 16'h0040 → both stale responses dropped (drop_cnt 2→0). First deq_pc=16'h0040 with mem[0x40] data.
- FIFO holding 3 entries, redirect and deq_ready asserted together → deq_valid=0 that cycle, count=0 next cycle, next deq_pc=redirect_pc.
- Redirect to 16'hFFFE → deq_pc sequence FFFE, FFFF, 0000, 0001; imem_addr wraps likewise.
- Drop rst_n mid-stream with 2 outstanding → deq_valid/count/imem_req 0 immediately, imem_addr=RESET_PC. Late stale imem_rvalid after release → err=1 and remains 1; FIFO unaffected.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches to instruction memory, buffers
// returned instructions with their PCs and hands them to the fetch stage; flushes on redirect.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           redirect_i,
   input  logic [15:0]                    redirect_pc_i,
   output logic                           imem_req_o,
   output logic [15:0]                    imem_addr_o,
   input  logic                           imem_ready_i,
   input  logic                           imem_rvalid_i,
   input  logic [15:0]                    imem_rdata_i,
   output logic                           deq_valid_o,
   output logic [15:0]                    deq_instr_o,
   output logic [15:0]                    deq_pc_o,
   input  logic                           deq_ready_i,
   output logic [$clog2(DEPTH + 1) - 1:0] count_o,
   output logic                           err_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam logic [CntW:0] DepthC = (CntW + 1)'(DEPTH);

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
   } entry_t;

   entry_t fifo_q [DEPTH];

   logic [15:0]     fetch_pc_q, fetch_pc_d;
   logic [15:0]     resp_pc_q, resp_pc_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [CntW-1:0] outst_q, outst_d;
   logic [CntW-1:0] drop_q, drop_d;
   logic            err_q, err_d;

   logic credit_ok;
   logic accept;
   logic rsp_live;
   logic rsp_orphan;
   logic dropping;
   logic push;
   logic pop;

   // Outstanding requests (including ones to be dropped) reserve a slot, so a push never
   // finds the FIFO full.
   always_comb begin
      credit_ok   = ({1'b0, count_q} + {1'b0, outst_q}) < DepthC;
      imem_req_o  = rst_ni && !redirect_i && credit_ok;
      imem_addr_o = fetch_pc_q;
      accept      = imem_req_o && imem_ready_i;
      rsp_live    = imem_rvalid_i && (outst_q != '0);
      rsp_orphan  = imem_rvalid_i && (outst_q == '0);
      dropping    = (drop_q != '0);
      deq_valid_o = (count_q != '0) && !redirect_i;
      deq_instr_o = fifo_q[rd_ptr_q].instr;
      deq_pc_o    = fifo_q[rd_ptr_q].pc;
      pop         = deq_valid_o && deq_ready_i;
      push        = rsp_live && !redirect_i && !dropping;
      count_o     = count_q;
      err_o       = err_q;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      outst_d    = outst_q;
      drop_d     = drop_q;
      err_d      = err_q | rsp_orphan;

      if (redirect_i) begin
         // Everything still in flight is stale; a response landing now is discarded too.
         fetch_pc_d = redirect_pc_i;
         resp_pc_d  = redirect_pc_i;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         outst_d    = outst_q - CntW'(rsp_live);
         drop_d     = outst_d;
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + 16'd1;
         end
         if (push) begin
            wr_ptr_d  = wr_ptr_q + PtrW'(1);
            resp_pc_d = resp_pc_q + 16'd1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         if (rsp_live && dropping) begin
            drop_d = drop_q - CntW'(1);
         end
         count_d = count_q + CntW'(push) - CntW'(pop);
         outst_d = outst_q + CntW'(accept) - CntW'(rsp_live);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         outst_q    <= '0;
         drop_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         err_q      <= err_d;
      end
   end

   // Storage carries no reset; contents are only observed once count is non-zero.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= '{instr: imem_rdata_i, pc: resp_pc_q};
      end
   end

   push_not_full_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      push |-> (count_q < CntW'(DEPTH)));

   credit_bound_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      ({1'b0, count_q} + {1'b0, outst_q}) <= DepthC);

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue: a queue-based reference model and an in-order memory model
// are checked against the DUT every cycle, with directed scenarios pinning literal values.
module tb_fetch_queue;

   localparam int unsigned DEPTH    = 4;
   localparam logic [15:0] RESET_PC = 16'h0000;
   localparam int unsigned CntW     = $clog2(DEPTH + 1);

   logic            clk = 1'b0;
   logic            rst_n;
   logic            redirect;
   logic [15:0]     redirect_pc;
   logic            imem_req;
   logic [15:0]     imem_addr;
   logic            imem_ready;
   logic            imem_rvalid;
   logic [15:0]     imem_rdata;
   logic            deq_valid;
   logic [15:0]     deq_instr;
   logic [15:0]     deq_pc;
   logic            deq_ready;
   logic [CntW-1:0] count;
   logic            err;

   always #5 clk = ~clk;

   fetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_ready_i  (imem_ready),
      .imem_rvalid_i (imem_rvalid),
      .imem_rdata_i  (imem_rdata),
      .deq_valid_o   (deq_valid),
      .deq_instr_o   (deq_instr),
      .deq_pc_o      (deq_pc),
      .deq_ready_i   (deq_ready),
      .count_o       (count),
      .err_o         (err)
   );

   typedef struct { logic [15:0] pc; bit stale; } req_t;
   typedef struct { logic [15:0] instr; logic [15:0] pc; } ent_t;
   typedef struct { logic [15:0] addr; int due; } mreq_t;

   // Reference model: requests in flight (tagged stale after a redirect) and buffered entries.
   req_t        outq[$];
   ent_t        fifo[$];
   logic [15:0] m_fetch_pc;
   bit          m_err;

   mreq_t       mem_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int          k_redir_pct, k_rdy_pct, k_irdy_pct, k_lat_min, k_lat_max;
   bit          f_redir = 1'b0;
   logic [15:0] f_pc;

   logic [15:0] pop_pc[$];
   logic [15:0] pop_instr[$];
   bit          last_valid;
   int          first_valid_cyc;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return a ^ 16'hA5A5;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_knobs(input int redir, input int rdy, input int irdy, input int lmin,
                            input int lmax);
      k_redir_pct = redir;
      k_rdy_pct   = rdy;
      k_irdy_pct  = irdy;
      k_lat_min   = lmin;
      k_lat_max   = lmax;
   endtask

   task automatic model_reset();
      outq.delete();
      fifo.delete();
      m_fetch_pc = RESET_PC;
      m_err      = 1'b0;
   endtask

   task automatic step();
      logic exp_req, exp_valid;
      req_t r;
      int   lat;
      @(negedge clk);
      if (f_redir) begin
         redirect    = 1'b1;
         redirect_pc = f_pc;
         f_redir     = 1'b0;
      end else begin
         redirect    = ($urandom_range(99) < k_redir_pct);
         redirect_pc = ($urandom_range(3) == 0) ? 16'hFFFC + 16'($urandom_range(3))
                                                : 16'($urandom);
      end
      deq_ready  = ($urandom_range(99) < k_rdy_pct);
      imem_ready = ($urandom_range(99) < k_irdy_pct);
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(mem_q[0].addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 16'($urandom);
      end
      #1;
      exp_req   = !redirect && (fifo.size() + outq.size() < DEPTH);
      exp_valid = !redirect && (fifo.size() > 0);
      check("imem_req", imem_req, exp_req);
      check("imem_addr", imem_addr, m_fetch_pc);
      check("deq_valid", deq_valid, exp_valid);
      check("count", count, fifo.size());
      check("err", err, m_err);
      if (exp_valid) begin
         check("deq_pc", deq_pc, fifo[0].pc);
         check("deq_instr", deq_instr, fifo[0].instr);
      end
      if (deq_valid && deq_ready) begin
         pop_pc.push_back(deq_pc);
         pop_instr.push_back(deq_instr);
      end
      if (deq_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      last_valid = deq_valid;

      // Memory environment answers the DUT's actual handshake, in order.
      if (imem_rvalid) void'(mem_q.pop_front());
      if (imem_req && imem_ready) begin
         lat = int'($urandom_range(k_lat_max, k_lat_min));
         mem_q.push_back('{addr: imem_addr, due: cyc + lat});
      end

      if (imem_rvalid && outq.size() == 0) m_err = 1'b1;
      if (redirect) begin
         if (imem_rvalid && outq.size() > 0) void'(outq.pop_front());
         foreach (outq[i]) outq[i].stale = 1'b1;
         fifo.delete();
         m_fetch_pc = redirect_pc;
      end else begin
         if (exp_valid && deq_ready) void'(fifo.pop_front());
         if (imem_rvalid && outq.size() > 0) begin
            r = outq.pop_front();
            if (!r.stale) fifo.push_back('{instr: imem_rdata, pc: r.pc});
         end
         if (exp_req && imem_ready) begin
            outq.push_back('{pc: m_fetch_pc, stale: 1'b0});
            m_fetch_pc = m_fetch_pc + 16'd1;
         end
      end
      cyc++;
   endtask

   task automatic drain();
      set_knobs(0, 100, 0, 1, 1);
      for (int i = 0; i < 60; i++) begin
         if (mem_q.size() == 0 && fifo.size() == 0 && outq.size() == 0) break;
         step();
      end
      check("drain", fifo.size() + outq.size() + mem_q.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] wrap_seq[4];
      int          n0;
      wrap_seq = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

      rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = '0; deq_ready = 1'b0;
      first_valid_cyc = -1;
      set_knobs(0, 100, 100, 1, 1);
      model_reset();
      #2;
      check("rst deq_valid", deq_valid, 0);
      check("rst count", count, 0);
      check("rst imem_req", imem_req, 0);
      check("rst err", err, 0);
      check("rst imem_addr", imem_addr, 16'h0000);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Streaming with 1-cycle memory: one instruction per cycle after fill.
      pop_pc.delete(); pop_instr.delete();
      repeat (20) step();
      check("stream pops", pop_pc.size(), 18);
      if (pop_pc.size() >= 3) begin
         check("stream pc0", pop_pc[0], 16'h0000);
         check("stream pc1", pop_pc[1], 16'h0001);
         check("stream pc2", pop_pc[2], 16'h0002);
         check("stream instr0", pop_instr[0], 16'hA5A5);
         check("stream instr1", pop_instr[1], 16'hA5A4);
         check("stream instr2", pop_instr[2], 16'hA5A7);
      end

      // Stall: fills to DEPTH with nothing outstanding, then resumes in order.
      set_knobs(0, 0, 100, 1, 1);
      repeat (10) step();
      check("stall count", count, 4);
      check("stall imem_req", imem_req, 0);
      pop_pc.delete(); pop_instr.delete();
      set_knobs(0, 100, 100, 1, 1);
      repeat (10) step();
      check("resume pops", pop_pc.size() >= 4, 1);
      if (pop_pc.size() >= 4) begin
         for (int i = 0; i < 4; i++) check("resume pc", pop_pc[i], 16'(18 + i));
      end

      // Two stale requests at 3-cycle latency, then redirect to 0x0040.
      drain();
      set_knobs(0, 100, 100, 3, 3);
      step(); step();
      set_knobs(0, 100, 0, 3, 3);
      f_redir = 1'b1; f_pc = 16'h0040;
      step();
      set_knobs(0, 100, 100, 3, 3);
      pop_pc.delete(); pop_instr.delete();
      repeat (10) step();
      check("redir40 pops", pop_pc.size() > 0, 1);
      if (pop_pc.size() > 0) begin
         check("redir40 pc", pop_pc[0], 16'h0040);
         check("redir40 instr", pop_instr[0], 16'hA5E5);
      end

      // Redirect with deq_ready while three entries are buffered.
      set_knobs(0, 0, 100, 1, 1);
      for (int i = 0; i < 20 && fifo.size() != 3; i++) step();
      pop_pc.delete(); pop_instr.delete();
      set_knobs(0, 100, 100, 1, 1);
      f_redir = 1'b1; f_pc = 16'h0100;
      step();
      check("redir+ready count", count, 3);
      check("redir+ready deq_valid", last_valid, 0);
      step();
      check("post-redir count", count, 0);
      repeat (8) step();
      check("redir100 pops", pop_pc.size() > 0, 1);
      if (pop_pc.size() > 0) check("redir100 pc", pop_pc[0], 16'h0100);

      // Wrap-around target and minimum redirect-to-valid latency.
      drain();
      set_knobs(0, 100, 100, 1, 1);
      f_redir = 1'b1; f_pc = 16'hFFFE;
      first_valid_cyc = -1;
      pop_pc.delete(); pop_instr.delete();
      n0 = cyc;
      repeat (10) step();
      check("redirect latency", first_valid_cyc - n0, 3);
      check("wrap pops", pop_pc.size() >= 4, 1);
      if (pop_pc.size() >= 4) begin
         for (int i = 0; i < 4; i++) check("wrap pc", pop_pc[i], wrap_seq[i]);
      end

      // Random traffic, redirects and back-pressure.
      set_knobs(5, 70, 70, 1, 4);
      repeat (1500) step();
      set_knobs(8, 20, 90, 1, 3);
      repeat (1000) step();

      // Asynchronous reset with two responses still in flight.
      drain();
      set_knobs(0, 0, 100, 4, 4);
      repeat (6) step();
      @(negedge clk);
      redirect = 1'b0; imem_rvalid = 1'b0; imem_ready = 1'b0;
      #1;
      check("pre-reset count", count, 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("async deq_valid", deq_valid, 0);
      check("async count", count, 0);
      check("async imem_req", imem_req, 0);
      check("async imem_addr", imem_addr, RESET_PC);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      set_knobs(0, 100, 0, 1, 1);
      for (int i = 0; i < 20 && mem_q.size() != 0; i++) step();
      check("late responses drained", mem_q.size(), 0);
      @(negedge clk); #1;
      check("late err", err, 1);
      check("late count", count, 0);
      set_knobs(0, 100, 100, 1, 1);
      repeat (8) step();
      check("err sticky", err, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
